// File: rtl/video_timing_gen.sv
// Raster timing generator for the 1280x720p60 display path.
// Produces free-running pixel/line pointers, syncs, data-enable, line and
// frame strobes, and a frame counter. Every output is registered.
// Handshake: PIX_EN is a plain advance qualifier with no back-pressure.
// When PIX_EN is high on a CLK edge, the raster steps by one pixel. When it
// is low, all state holds and both strobes read 0.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PIX_EN,
  output logic [10:0] H_CNT,
  output logic [10:0] V_CNT,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic        LINE_START,
  output logic        FRAME_START,
  output logic [7:0]  FRAME_CNT,
  output logic [1:0]  H_PHASE,
  output logic [1:0]  V_PHASE
);

  // Both totals are expected to fit the 11-bit pointers (<= 2047).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SY_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SY_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

  phase_t      h_state, h_state_nxt;
  phase_t      v_state, v_state_nxt;
  logic [10:0] h_cnt_nxt, v_cnt_nxt;
  logic        h_wrap, v_wrap, v_adv;
  logic        started;
  logic        hsync_nxt, vsync_nxt, de_nxt;
  logic        line_start_nxt, frame_start_nxt;
  logic [7:0]  frame_cnt_nxt;

  assign H_PHASE = h_state;
  assign V_PHASE = v_state;

  // Next pixel/line pointers; the line pointer steps only on a line wrap.
  always_comb begin
    h_wrap    = (H_CNT == H_LAST);
    v_wrap    = (V_CNT == V_LAST);
    v_adv     = PIX_EN && h_wrap;
    h_cnt_nxt = H_CNT;
    v_cnt_nxt = V_CNT;
    if (PIX_EN) begin
      h_cnt_nxt = h_wrap ? 11'd0 : H_CNT + 11'd1;
    end
    if (v_adv) begin
      v_cnt_nxt = v_wrap ? 11'd0 : V_CNT + 11'd1;
    end
  end

  // Phase transitions fire on the edge that loads the first count of the new phase.
  always_comb begin
    h_state_nxt = h_state;
    case (h_state)
      PH_ACT:  if (PIX_EN && h_cnt_nxt == H_FP_START) h_state_nxt = PH_FP;
      PH_FP:   if (PIX_EN && h_cnt_nxt == H_SY_START) h_state_nxt = PH_SYNC;
      PH_SYNC: if (PIX_EN && h_cnt_nxt == H_BP_START) h_state_nxt = PH_BP;
      PH_BP:   if (PIX_EN && h_cnt_nxt == 11'd0)      h_state_nxt = PH_ACT;
      default: h_state_nxt = PH_BP;
    endcase
    v_state_nxt = v_state;
    case (v_state)
      PH_ACT:  if (v_adv && v_cnt_nxt == V_FP_START) v_state_nxt = PH_FP;
      PH_FP:   if (v_adv && v_cnt_nxt == V_SY_START) v_state_nxt = PH_SYNC;
      PH_SYNC: if (v_adv && v_cnt_nxt == V_BP_START) v_state_nxt = PH_BP;
      PH_BP:   if (v_adv && v_cnt_nxt == 11'd0)      v_state_nxt = PH_ACT;
      default: v_state_nxt = PH_BP;
    endcase
  end

  // Output decode from the upcoming phases, so outputs align with the pointers.
  always_comb begin
    hsync_nxt       = (h_state_nxt == PH_SYNC) ? HS_POL : ~HS_POL;
    vsync_nxt       = (v_state_nxt == PH_SYNC) ? VS_POL : ~VS_POL;
    de_nxt          = (h_state_nxt == PH_ACT) && (v_state_nxt == PH_ACT);
    line_start_nxt  = v_adv;
    frame_start_nxt = v_adv && v_wrap;
    frame_cnt_nxt   = FRAME_CNT;
    if (frame_start_nxt && started) begin
      frame_cnt_nxt = FRAME_CNT + 8'd1;
    end
  end

  // Pointer and phase registers; reset parks the raster on the last pixel of the frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      H_CNT   <= H_LAST;
      V_CNT   <= V_LAST;
      h_state <= PH_BP;
      v_state <= PH_BP;
      started <= 1'b0;
    end else begin
      H_CNT   <= h_cnt_nxt;
      V_CNT   <= v_cnt_nxt;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
      if (PIX_EN) started <= 1'b1;
    end
  end

  // Registered outputs; the first frame after reset does not bump FRAME_CNT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      DE          <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= 8'd0;
    end else begin
      HSYNC       <= hsync_nxt;
      VSYNC       <= vsync_nxt;
      DE          <= de_nxt;
      LINE_START  <= line_start_nxt;
      FRAME_START <= frame_start_nxt;
      FRAME_CNT   <= frame_cnt_nxt;
    end
  end

endmodule
